// File: rtl/dts_sample_pipe.sv
// Registered, flow-controlled DTS sample builder: 3-bit interleave / wide-sample maps,
// frame-boundary mode latch, frame-length check. DTS_SAMPLE_PIPE_FRAME_CNT_EN adds frame_cnt.

module dts_sample_lane #(
    parameter int WIDE_BITS = 8,
    parameter int OUT_BITS  = 12
) (
    input  logic [WIDE_BITS-1:0]   top,
    input  logic [WIDE_BITS-1:0]   mid,
    input  logic [WIDE_BITS-1:0]   bot,
    output logic [3*WIDE_BITS-1:0] three_bit,
    output logic [2*OUT_BITS-1:0]  wide
);
    always_comb begin
        three_bit = '0;
        for (int i = 0; i < WIDE_BITS; i++)
            three_bit[3*i +: 3] = {top[i], mid[i], bot[i]};
    end

    // input word left-justified in its sample; bottom is the lower-numbered sample
    assign wide = {OUT_BITS'(top) << (OUT_BITS - WIDE_BITS),
                   OUT_BITS'(bot) << (OUT_BITS - WIDE_BITS)};
endmodule

module dts_sample_pipe #(
    parameter int INPUT_WIDTH = 128,
    parameter int WIDE_BITS   = 8,
    parameter int OUT_BITS    = 12,
    parameter int FRAME_BEATS = 1024,
    parameter int ERR_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_three_bit,
    input  logic [3*INPUT_WIDTH-1:0] s_data,
    input  logic                     s_sync,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [3*INPUT_WIDTH-1:0] m_data,
    output logic                     m_sync,
    output logic                     m_three_bit,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     locked,
    output logic                     sync_err,
    output logic [ERR_W-1:0]         sync_err_cnt
`ifdef DTS_SAMPLE_PIPE_FRAME_CNT_EN
    ,
    output logic [31:0]              frame_cnt
`endif
);
    localparam int LANES = INPUT_WIDTH / WIDE_BITS;
    localparam int DW    = 3 * INPUT_WIDTH;
    localparam int CW    = $clog2(FRAME_BEATS);

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sync;
        logic          three_bit;
    } beat_t;

    logic [2:1]    vld_pipe;
    beat_t         s1_d, s1_q, s2_q;
    logic          ld1, ld2, acc;
    logic          mode_q, mode_eff, locked_q;
    logic [CW-1:0] cnt_q;
    logic          last_beat, err_d;

    logic [LANES-1:0][3*WIDE_BITS-1:0] lane_three;
    logic [LANES-1:0][2*OUT_BITS-1:0]  lane_wide;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        dts_sample_lane #(
            .WIDE_BITS (WIDE_BITS),
            .OUT_BITS  (OUT_BITS)
        ) u_lane (
            .top       (s_data[2*INPUT_WIDTH + k*WIDE_BITS +: WIDE_BITS]),
            .mid       (s_data[INPUT_WIDTH + k*WIDE_BITS +: WIDE_BITS]),
            .bot       (s_data[k*WIDE_BITS +: WIDE_BITS]),
            .three_bit (lane_three[k]),
            .wide      (lane_wide[k])
        );
    end

    // a stage loads when empty or when its occupant moves on this cycle
    assign ld2     = !vld_pipe[2] || m_ready;
    assign ld1     = !vld_pipe[1] || ld2;
    assign s_ready = ld1;
    assign acc     = s_valid && s_ready;

    // a sync beat is built with the mode it brings in
    assign mode_eff = s_sync ? cfg_three_bit : mode_q;

    always_comb begin
        s1_d           = '0;
        s1_d.sync      = s_sync;
        s1_d.three_bit = mode_eff;
        s1_d.data      = mode_eff ? DW'(lane_three) : DW'(lane_wide);
    end

    assign last_beat = (cnt_q == CW'(FRAME_BEATS - 1));
    assign err_d     = acc && locked_q && (s_sync != last_beat);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe     <= '0;
            s1_q         <= '0;
            s2_q         <= '0;
            mode_q       <= 1'b0;
            locked_q     <= 1'b0;
            cnt_q        <= '0;
            sync_err     <= 1'b0;
            sync_err_cnt <= '0;
        end else begin
            if (ld2) begin
                vld_pipe[2] <= vld_pipe[1];
                s2_q        <= s1_q;
            end
            if (ld1) begin
                vld_pipe[1] <= s_valid;
                if (s_valid)
                    s1_q <= s1_d;
            end

            sync_err <= err_d;
            if (err_d && sync_err_cnt != '1)
                sync_err_cnt <= sync_err_cnt + ERR_W'(1);

            // both error kinds and a clean wrap restart the frame at 0
            if (acc) begin
                if (s_sync) begin
                    mode_q   <= cfg_three_bit;
                    locked_q <= 1'b1;
                end
                if (s_sync || last_beat)
                    cnt_q <= '0;
                else if (locked_q)
                    cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign m_valid     = vld_pipe[2];
    assign m_data      = s2_q.data;
    assign m_sync      = s2_q.sync;
    assign m_three_bit = s2_q.three_bit;
    assign locked      = locked_q;

`ifdef DTS_SAMPLE_PIPE_FRAME_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            frame_cnt <= '0;
        else if (vld_pipe[2] && m_ready && s2_q.sync)
            frame_cnt <= frame_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_dts_sample_pipe.sv
// Bench for dts_sample_pipe: vector table, mode/frame/reset sequences, random flow-control run
// against a scoreboard model.

module tb_dts_sample_pipe;
    localparam int IW = 128;
    localparam int WB = 8;
    localparam int OB = 12;
    localparam int FB = 4;
    localparam int EW = 4;
    localparam int DW = 3 * IW;
    localparam int NW = IW / WB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_three_bit = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_sync = 1'b0;
    logic          s_valid = 1'b0;
    logic          m_ready = 1'b0;
    logic          s_ready, m_sync, m_three_bit, m_valid, locked, sync_err;
    logic [DW-1:0] m_data;
    logic [EW-1:0] sync_err_cnt;
`ifdef DTS_SAMPLE_PIPE_FRAME_CNT_EN
    logic [31:0]   frame_cnt;
`endif

    always #5 clk = ~clk;

    dts_sample_pipe #(
        .INPUT_WIDTH (IW),
        .WIDE_BITS   (WB),
        .OUT_BITS    (OB),
        .FRAME_BEATS (FB),
        .ERR_W       (EW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_three_bit (cfg_three_bit),
        .s_data        (s_data),
        .s_sync        (s_sync),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .m_data        (m_data),
        .m_sync        (m_sync),
        .m_three_bit   (m_three_bit),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .locked        (locked),
        .sync_err      (sync_err),
        .sync_err_cnt  (sync_err_cnt)
`ifdef DTS_SAMPLE_PIPE_FRAME_CNT_EN
        ,
        .frame_cnt     (frame_cnt)
`endif
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          sync;
        logic          three;
    } exp_t;

    typedef struct {
        logic          three;
        logic [IW-1:0] top;
        logic [IW-1:0] mid;
        logic [IW-1:0] bot;
        logic [DW-1:0] exp;
    } vec_t;

    int   total = 0;
    int   bad = 0;
    exp_t sbq[$];
    bit   three_log[$];
    bit   mdl_locked = 0;
    bit   mdl_mode = 0;
    int   mdl_since = 0;
    int   mdl_errcnt = 0;
    int   out_syncs = 0;
    bit   err_pend = 0;
    int   err_pulses = 0;
    bit   last_acc = 0;
    bit   prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic prev_sync, prev_three;

    vec_t vt[6];
    bit   mt_sync[9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    bit   mt_cfg[9]  = '{0, 1, 1, 1, 1, 0, 0, 0, 0};
    bit   mt_exp[9]  = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    bit   fe_sync[8] = '{1, 0, 1, 0, 0, 0, 0, 0};
    int   beats, gen_pos, cyc;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // reference map, bit by bit from the stream layout
    function automatic logic [DW-1:0] ref_map(input logic [DW-1:0] d, input bit three);
        logic [DW-1:0] r = '0;
        if (three) begin
            for (int i = 0; i < IW; i++) begin
                r[3*i+2] = d[2*IW+i];
                r[3*i+1] = d[IW+i];
                r[3*i]   = d[i];
            end
        end else begin
            for (int k = 0; k < NW; k++) begin
                r[(2*k+1)*OB +: OB] = {d[2*IW + WB*k +: WB], {(OB-WB){1'b0}}};
                r[2*k*OB +: OB]     = {d[WB*k +: WB], {(OB-WB){1'b0}}};
            end
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int w = 0; w < DW/32; w++) r[32*w +: 32] = $urandom();
        return r;
    endfunction

    // called once per cycle at the falling edge: check state, then account for this edge's handshakes
    task automatic monitor();
        int   inflight;
        bit   err;
        bit   ms;
        exp_t e;
        inflight = sbq.size();
        chk("sync_err", sync_err, err_pend);
        chk("sync_err_cnt", sync_err_cnt, mdl_errcnt);
        chk("locked", locked, mdl_locked);
        chk("s_ready", s_ready, (inflight < 2) || m_ready);
`ifdef DTS_SAMPLE_PIPE_FRAME_CNT_EN
        chk("frame_cnt", frame_cnt, out_syncs);
`endif
        if (sync_err === 1'b1) err_pulses++;
        if (prev_stall) begin
            chk("hold m_valid", m_valid, 1);
            chk("hold m_data", m_data, prev_data);
            chk("hold m_sync", m_sync, prev_sync);
            chk("hold m_three_bit", m_three_bit, prev_three);
        end
        err_pend = 0;
        last_acc = 0;
        if (!rst_n) begin
            sbq.delete();
            mdl_locked = 0; mdl_mode = 0; mdl_since = 0; mdl_errcnt = 0; out_syncs = 0;
            prev_stall = 0;
            return;
        end
        if (s_valid && s_ready) begin
            err = 0;
            if (mdl_locked) begin
                err = s_sync ? (mdl_since != FB) : (mdl_since == FB);
                if (s_sync || mdl_since == FB) mdl_since = 1;
                else mdl_since++;
            end else if (s_sync) begin
                mdl_locked = 1;
                mdl_since  = 1;
            end
            if (s_sync) mdl_mode = cfg_three_bit;
            if (err) begin
                err_pend = 1;
                if (mdl_errcnt < 2**EW - 1) mdl_errcnt++;
            end
            ms = s_sync;
            sbq.push_back('{ref_map(s_data, mdl_mode), ms, mdl_mode});
            last_acc = 1;
        end
        if (m_valid && m_ready) begin
            if (sbq.size() == 0) begin
                total++; bad++;
                $display("FAIL out_extra: got unexpected beat %0h want none", m_data);
            end else begin
                e = sbq.pop_front();
                chk("m_data", m_data, e.data);
                chk("m_sync", m_sync, e.sync);
                chk("m_three_bit", m_three_bit, e.three);
                three_log.push_back(m_three_bit);
                if (e.sync) out_syncs++;
            end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_sync  = m_sync;
        prev_three = m_three_bit;
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        s_valid = 0;
        s_sync  = 0;
        m_ready = 1;
        for (int i = 0; i < 8; i++) cycle();
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d beats left want 0", sbq.size());
        end
    endtask

    task automatic do_reset();
        rst_n   = 0;
        s_valid = 0;
        s_sync  = 0;
        cycle();
        rst_n = 1;
    endtask

    initial begin
        vt[0] = '{1'b1, {IW{1'b1}}, {IW{1'b0}}, {IW{1'b0}}, {IW{3'b100}}};
        vt[1] = '{1'b1, {IW{1'b0}}, {IW{1'b1}}, {IW{1'b0}}, {IW{3'b010}}};
        vt[2] = '{1'b1, {IW{1'b0}}, {IW{1'b0}}, {IW{1'b1}}, {IW{3'b001}}};
        vt[3] = '{1'b0, {IW{1'b0}}, {IW{1'b1}}, {IW{1'b0}}, {DW{1'b0}}};
        vt[4] = '{1'b0, {IW{1'b0}}, {IW{1'b0}}, {IW{1'b0}}, {DW{1'b0}}};
        vt[5] = '{1'b0, {IW{1'b1}}, {IW{1'b0}}, {IW{1'b0}}, {DW{1'b0}}};
        for (int k = 0; k < NW; k++) begin
            vt[4].top[k*WB +: WB]     = WB'(k);
            vt[4].bot[k*WB +: WB]     = WB'(8'h80 + k);
            vt[4].exp[(2*k+1)*OB +: OB] = {WB'(k), 4'h0};
            vt[4].exp[2*k*OB +: OB]     = {WB'(8'h80 + k), 4'h0};
            vt[5].exp[(2*k+1)*OB +: OB] = 12'hff0;
        end

        // power-up reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst m_valid", m_valid, 0);
        chk("rst m_sync", m_sync, 0);
        chk("rst m_data", m_data, 0);
        chk("rst sync_err", sync_err, 0);
        chk("rst sync_err_cnt", sync_err_cnt, 0);
        chk("rst locked", locked, 0);
        chk("rst s_ready", s_ready, 1);
        rst_n = 1;

        // vector table: one sync beat each, latency and map checked against constants
        m_ready = 1;
        foreach (vt[i]) begin
            cfg_three_bit = vt[i].three;
            s_sync  = 1;
            s_valid = 1;
            s_data  = {vt[i].top, vt[i].mid, vt[i].bot};
            cycle();
            s_valid = 0;
            s_sync  = 0;
            chk("vec m_valid at N+1", m_valid, 0);
            cycle();
            chk("vec m_valid at N+2", m_valid, 1);
            chk("vec m_data", m_data, vt[i].exp);
            chk("vec m_three_bit", m_three_bit, vt[i].three);
            chk("vec m_sync", m_sync, 1);
        end
        drain();

        // mode toggled mid-frame takes effect only on the next sync
        do_reset();
        three_log.delete();
        m_ready = 1;
        for (int i = 0; i < 9; i++) begin
            s_valid = 1;
            s_sync  = mt_sync[i];
            cfg_three_bit = mt_cfg[i];
            s_data  = rnd();
            cycle();
        end
        drain();
        chk("mode log length", three_log.size(), 9);
        for (int i = 0; i < 9 && i < three_log.size(); i++)
            chk("mode per beat", three_log[i], mt_exp[i]);

        // early sync at beat 2, missing sync at beat 6
        do_reset();
        err_pulses = 0;
        m_ready = 1;
        for (int i = 0; i < 8; i++) begin
            s_valid = 1;
            s_sync  = fe_sync[i];
            cfg_three_bit = 0;
            s_data  = rnd();
            cycle();
        end
        drain();
        chk("frame err pulses", err_pulses, 2);
        chk("frame err count", sync_err_cnt, 2);
        chk("frame locked", locked, 1);

        // reset with two beats in flight
        m_ready = 0;
        s_valid = 1;
        s_sync  = 0;
        s_data  = rnd();
        cycle();
        s_data  = rnd();
        cycle();
        chk("in-flight m_valid", m_valid, 1);
        s_valid = 0;
        rst_n   = 0;
        cycle();
        rst_n = 1;
        chk("midrst m_valid", m_valid, 0);
        chk("midrst sync_err_cnt", sync_err_cnt, 0);
        chk("midrst locked", locked, 0);
        chk("midrst s_ready", s_ready, 1);
        drain();

        // random flow control, occasional frame errors (counter saturates at 15)
        beats   = 0;
        gen_pos = 0;
        cyc     = 0;
        while (beats < 10000 && cyc < 60000) begin
            s_valid = ($urandom_range(0, 9) < 7);
            m_ready = $urandom_range(0, 1);
            cfg_three_bit = $urandom_range(0, 1);
            s_sync  = ((gen_pos % FB) == 0) ^ ($urandom_range(0, 31) == 0);
            s_data  = rnd();
            cycle();
            cyc++;
            if (last_acc) begin
                beats++;
                gen_pos++;
            end
        end
        chk("random beats accepted", beats, 10000);
        drain();
        chk("random err count saturated", sync_err_cnt, 2**EW - 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
